// File: rtl/answer_judge.sv
// answer_judge: verdict stage of the factorization game.
// Captures the three answer digits and the BCD question on a fresh DEC press
// in INPUT, multiplies the digits, converts the question to binary, and
// issues a registered verdict plus the time the player took.

// Per-digit legality check: zero, non-BCD, or (optionally) non-prime digits
// can never form a valid answer.
module aj_digit_chk #(
    parameter int PRIME_ONLY = 1
) (
    input  logic [3:0] i_digit,
    output logic       o_bad
);
    logic w_prime;

    // Flag a digit that disqualifies the answer regardless of the product
    always_comb begin
        w_prime = (i_digit == 4'd2) || (i_digit == 4'd3) ||
                  (i_digit == 4'd5) || (i_digit == 4'd7);
        o_bad   = (i_digit == 4'd0) || (i_digit > 4'd9) ||
                  ((PRIME_ONLY != 0) && !w_prime);
    end
endmodule

module answer_judge #(
    parameter int TIME_W     = 16,
    parameter int PRIME_ONLY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_state,
    input  logic [23:0]       i_question,
    input  logic              i_dec,
    input  logic [3:0]        i_count1_out,
    input  logic [3:0]        i_count2_out,
    input  logic [3:0]        i_count3_out,
    output logic [1:0]        o_result,
    output logic              o_result_valid,
    output logic              o_busy,
    output logic [TIME_W-1:0] o_ans_time
);
    localparam logic [3:0] ST_READY  = 4'b0010;
    localparam logic [3:0] ST_INPUT  = 4'b0100;
    localparam logic [1:0] RES_NONE  = 2'b00;
    localparam logic [1:0] RES_OK    = 2'b01;
    localparam logic [1:0] RES_WRONG = 2'b10;
    localparam logic [1:0] RES_INV   = 2'b11;
    localparam logic [TIME_W-1:0] TMR_MAX = '1;
    localparam logic [TIME_W-1:0] TMR_ONE = {{(TIME_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CAPT = 3'd1,
        S_MUL  = 3'd2,
        S_CMP  = 3'd3,
        S_DONE = 3'd4
    } fsm_t;

    fsm_t              r_fsm;
    fsm_t              w_nxt;
    logic              r_dec_d;
    logic [TIME_W-1:0] r_timer;
    logic [2:0][3:0]   r_d;        // [0]=ones digit .. [2]=hundreds-position digit
    logic [2:0][3:0]   r_q;        // [2]=hundreds .. [0]=ones of the question
    logic [6:0]        r_p12;
    logic [9:0]        r_qbin;
    logic              r_q_bad;
    logic              r_qzero;
    logic              r_d_bad;
    logic [1:0]        r_verdict;
    logic              r_vrd_rdy;  // verdict computed, not yet published
    logic [1:0]        r_result;
    logic              r_result_valid;
    logic              r_busy;
    logic [TIME_W-1:0] r_ans_time;

    logic              w_in_input;
    logic              w_in_ready;
    logic              w_dec_rise;
    logic              w_capt_en;
    logic              w_mul_en;
    logic              w_cmp_en;
    logic              w_done_en;
    logic              w_abort;
    logic              w_tmr_run;
    logic [2:0]        w_d_bad;
    logic              w_q_bad;
    logic [9:0]        w_qh;
    logic [9:0]        w_qt;
    logic [9:0]        w_qo;
    logic [9:0]        w_qbin;
    logic [6:0]        w_p12;
    logic [9:0]        w_p;
    logic [1:0]        w_verdict;
    logic              w_unused_qlow;

    // Low question bits belong to other display fields and play no part here
    assign w_unused_qlow = ^i_question[11:0];

    assign w_in_input = (i_state == ST_INPUT);
    assign w_in_ready = (i_state == ST_READY);
    assign w_dec_rise = i_dec & ~r_dec_d;

    // One legality checker per captured answer digit
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dchk
            aj_digit_chk #(.PRIME_ONLY(PRIME_ONLY)) u_dchk (
                .i_digit (r_d[gi]),
                .o_bad   (w_d_bad[gi])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_fsm <= S_IDLE;
        else       r_fsm <= w_nxt;
    end

    // Next-state: any pipeline step aborts if the game leaves INPUT;
    // DONE parks until INPUT is left so repeated presses are ignored
    always_comb begin
        w_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (w_in_input && w_dec_rise) w_nxt = S_CAPT;
            S_CAPT:  w_nxt = w_in_input ? S_MUL  : S_IDLE;
            S_MUL:   w_nxt = w_in_input ? S_CMP  : S_IDLE;
            S_CMP:   w_nxt = w_in_input ? S_DONE : S_IDLE;
            S_DONE:  if (!w_in_input) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    // Output decode: per-state strobes steering the datapath registers
    always_comb begin
        w_capt_en = (r_fsm == S_CAPT) && w_in_input;
        w_mul_en  = (r_fsm == S_MUL)  && w_in_input;
        w_cmp_en  = (r_fsm == S_CMP)  && w_in_input;
        w_done_en = (r_fsm == S_DONE) && r_vrd_rdy;
        w_abort   = ((r_fsm == S_CAPT) || (r_fsm == S_MUL) || (r_fsm == S_CMP))
                    && !w_in_input;
        w_tmr_run = (r_fsm == S_IDLE) && w_in_input;
    end

    // Question to binary with shifts and adds: h*100 = h*64+h*32+h*4, t*10 = t*8+t*2
    always_comb begin
        w_qh    = {6'd0, r_q[2]};
        w_qt    = {6'd0, r_q[1]};
        w_qo    = {6'd0, r_q[0]};
        w_qbin  = (w_qh << 6) + (w_qh << 5) + (w_qh << 2) +
                  (w_qt << 3) + (w_qt << 1) + w_qo;
        w_q_bad = (r_q[2] > 4'd9) || (r_q[1] > 4'd9) || (r_q[0] > 4'd9);
        w_p12   = {3'd0, r_d[0]} * {3'd0, r_d[1]};
    end

    // Final product and prioritised verdict: bad question beats bad answer
    always_comb begin
        w_p = {3'd0, r_p12} * {6'd0, r_d[2]};
        if (r_q_bad || r_qzero)  w_verdict = RES_INV;
        else if (r_d_bad)        w_verdict = RES_WRONG;
        else if (w_p == r_qbin)  w_verdict = RES_OK;
        else                     w_verdict = RES_WRONG;
    end

    // Registered DEC for edge detection; a held button cannot retrigger
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_dec_d <= 1'b0;
        else       r_dec_d <= i_dec;
    end

    // Answer timer: cleared in READY, counts idle INPUT cycles, saturates
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                r_timer <= '0;
        else if (w_in_ready)                      r_timer <= '0;
        else if (w_tmr_run && r_timer != TMR_MAX) r_timer <= r_timer + TMR_ONE;
    end

    // Operand capture one edge after the press, once the entry block has latched
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_d <= '0;
            r_q <= '0;
        end else if (w_capt_en) begin
            r_d <= {i_count3_out, i_count2_out, i_count1_out};
            r_q <= i_question[23:12];
        end
    end

    // Partial product, binary question and disqualification flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p12   <= '0;
            r_qbin  <= '0;
            r_q_bad <= 1'b0;
            r_qzero <= 1'b0;
            r_d_bad <= 1'b0;
        end else if (w_mul_en) begin
            r_p12   <= w_p12;
            r_qbin  <= w_qbin;
            r_q_bad <= w_q_bad;
            r_qzero <= (w_qbin == 10'd0);
            r_d_bad <= |w_d_bad;
        end
    end

    // Verdict register; the ready flag marks the single publishing edge in DONE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_verdict <= RES_NONE;
            r_vrd_rdy <= 1'b0;
        end else begin
            r_vrd_rdy <= w_cmp_en;
            if (w_cmp_en) r_verdict <= w_verdict;
        end
    end

    // Published result: written on the verdict edge, otherwise READY clears it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_result       <= RES_NONE;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= w_done_en;
            if (w_done_en)       r_result <= r_verdict;
            else if (w_in_ready) r_result <= RES_NONE;
        end
    end

    // Busy spans capture to verdict; answer time is frozen at capture
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy     <= 1'b0;
            r_ans_time <= '0;
        end else if (w_capt_en) begin
            r_busy     <= 1'b1;
            r_ans_time <= r_timer;
        end else if (w_abort || w_done_en) begin
            r_busy     <= 1'b0;
        end
    end

    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_busy         = r_busy;
    assign o_ans_time     = r_ans_time;
endmodule

// File: tb/tb_answer_judge.sv
// Bench for answer_judge: three instances share stimulus (prime-only,
// any-digit, and a 4-bit timer). Expected verdicts and times are queued when
// a press is driven and compared when the main instance pulses RESULT_VALID.
module tb_answer_judge;
    localparam logic [3:0] READY = 4'b0010;
    localparam logic [3:0] INPUT = 4'b0100;
    localparam logic [3:0] OTHER = 4'b1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  state;
    logic [23:0] question;
    logic        dec;
    logic [3:0]  c1, c2, c3;

    logic [1:0]  res, res_np, res_t4;
    logic        vld, vld_np, vld_t4;
    logic        busy, busy_np, busy_t4;
    logic [15:0] atime, atime_np;
    logic [3:0]  atime_t4;

    typedef struct packed {
        logic [1:0]  res;
        logic [1:0]  res_np;
        logic [15:0] t;
        logic [3:0]  t4;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   pulse_cnt = 0;

    always #5 clk = ~clk;

    answer_judge u_dut (
        .i_clk(clk), .i_rst(rst), .i_state(state), .i_question(question), .i_dec(dec),
        .i_count1_out(c1), .i_count2_out(c2), .i_count3_out(c3),
        .o_result(res), .o_result_valid(vld), .o_busy(busy), .o_ans_time(atime));

    answer_judge #(.PRIME_ONLY(0)) u_dut_np (
        .i_clk(clk), .i_rst(rst), .i_state(state), .i_question(question), .i_dec(dec),
        .i_count1_out(c1), .i_count2_out(c2), .i_count3_out(c3),
        .o_result(res_np), .o_result_valid(vld_np), .o_busy(busy_np), .o_ans_time(atime_np));

    answer_judge #(.TIME_W(4)) u_dut_t4 (
        .i_clk(clk), .i_rst(rst), .i_state(state), .i_question(question), .i_dec(dec),
        .i_count1_out(c1), .i_count2_out(c2), .i_count3_out(c3),
        .o_result(res_t4), .o_result_valid(vld_t4), .o_busy(busy_t4), .o_ans_time(atime_t4));

    // Scoreboard: every main-instance pulse must match the oldest queued entry
    always @(negedge clk) begin : mon
        exp_t e;
        if (vld === 1'b1) begin
            pulse_cnt++;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_pulse got result=%b, required no pulse", res);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (res !== e.res) begin
                    failures++;
                    $display("FAIL sb_result got=%b required=%b", res, e.res);
                end
                checks++;
                if (vld_np !== 1'b1 || res_np !== e.res_np) begin
                    failures++;
                    $display("FAIL sb_result_anydigit got vld=%b result=%b required vld=1 result=%b",
                             vld_np, res_np, e.res_np);
                end
                checks++;
                if (atime !== e.t) begin
                    failures++;
                    $display("FAIL sb_ans_time got=%0d required=%0d", atime, e.t);
                end
                checks++;
                if (vld_t4 !== 1'b1 || atime_t4 !== e.t4) begin
                    failures++;
                    $display("FAIL sb_ans_time_w4 got vld=%b time=%0d required vld=1 time=%0d",
                             vld_t4, atime_t4, e.t4);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic go_ready();
        state = READY;
        dec   = 1'b0;
        tick();
        tick();
    endtask

    // Enter INPUT, idle n cycles, then press DEC; returns just after edge k
    task automatic start(input logic [11:0] q, input logic [3:0] a, b, c, input int n);
        state    = INPUT;
        question = {q, 12'h000};
        c1 = a; c2 = b; c3 = c;
        dec = 1'b0;
        repeat (n) tick();
        dec = 1'b1;
        tick();
        dec = 1'b0;
    endtask

    task automatic do_judge(input logic [11:0] q, input logic [3:0] a, b, c, input int n,
                            input logic [1:0] r, input logic [1:0] rnp);
        exp_t e;
        bit   seen;
        go_ready();
        e.res    = r;
        e.res_np = rnp;
        e.t      = 16'(n + 1);
        e.t4     = (n + 1 > 15) ? 4'd15 : 4'(n + 1);
        sb_q.push_back(e);
        start(q, a, b, c, n);
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (vld === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL judge_timeout q=%h no RESULT_VALID within 12 cycles, required one", q);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; state = READY; question = '0; dec = 1'b0;
        c1 = '0; c2 = '0; c3 = '0;
        tick();
        tick();
        checks++;
        if (res !== 2'b00 || vld !== 1'b0 || busy !== 1'b0 || atime !== 16'd0) begin
            failures++;
            $display("FAIL reset_state got res=%b vld=%b busy=%b time=%0d required 0/0/0/0",
                     res, vld, busy, atime);
        end
        rst = 1'b0;
        tick();
    endtask

    // Product match with timing of BUSY and the one-cycle pulse, then DONE ignores DEC
    task automatic test_basic();
        exp_t e;
        int   base;
        go_ready();
        e = '{res: 2'b01, res_np: 2'b01, t: 16'd4, t4: 4'd4};
        sb_q.push_back(e);
        start(12'h105, 4'd3, 4'd5, 4'd7, 3);
        for (int i = 0; i <= 5; i++) begin
            if (i > 0) tick();
            checks++;
            if (busy !== (i >= 1 && i <= 3) || vld !== (i == 4)) begin
                failures++;
                $display("FAIL basic_timing cycle k+%0d got busy=%b vld=%b required busy=%b vld=%b",
                         i, busy, vld, (i >= 1 && i <= 3), (i == 4));
            end
        end
        base = pulse_cnt;
        dec = 1'b1;
        tick();
        dec = 1'b0;
        repeat (8) tick();
        checks++;
        if (pulse_cnt != base || busy !== 1'b0 || res !== 2'b01) begin
            failures++;
            $display("FAIL done_ignores_dec got pulses=%0d busy=%b res=%b required 0/0/01",
                     pulse_cnt - base, busy, res);
        end
    endtask

    task automatic test_wrong();
        do_judge(12'h105, 4'd3, 4'd5, 4'd8, 2, 2'b10, 2'b10);
        do_judge(12'h027, 4'd3, 4'd3, 4'd3, 2, 2'b01, 2'b01);
    endtask

    task automatic test_prime();
        do_judge(12'h036, 4'd4, 4'd9, 4'd1, 3, 2'b10, 2'b01);
        do_judge(12'h035, 4'd7, 4'd5, 4'd1, 1, 2'b10, 2'b01);
    endtask

    task automatic test_invalid();
        do_judge(12'h000, 4'd3, 4'd5, 4'd7, 2, 2'b11, 2'b11);
        do_judge(12'h0A5, 4'd3, 4'd5, 4'd7, 2, 2'b11, 2'b11);
        do_judge(12'h1F0, 4'd0, 4'd0, 4'd0, 2, 2'b11, 2'b11);
        do_judge(12'h105, 4'd0, 4'd5, 4'd7, 2, 2'b10, 2'b10);
        do_judge(12'h105, 4'hC, 4'd5, 4'd7, 2, 2'b10, 2'b10);
    endtask

    // Leaving INPUT mid-judgement, then async reset mid-judgement
    task automatic test_abort();
        int base;
        state = OTHER;
        tick();
        tick();
        base = pulse_cnt;
        start(12'h105, 4'd3, 4'd5, 4'd7, 2);
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_k1 got=%b required=1", busy);
        end
        state = OTHER;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy_k3 got=%b required=0", busy);
        end
        repeat (6) tick();
        checks++;
        if (pulse_cnt != base || res !== 2'b10) begin
            failures++;
            $display("FAIL abort_no_pulse got pulses=%0d res=%b required 0 pulses res=10",
                     pulse_cnt - base, res);
        end

        start(12'h105, 4'd3, 4'd5, 4'd7, 2);
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (res !== 2'b00 || vld !== 1'b0 || busy !== 1'b0 || atime !== 16'd0) begin
            failures++;
            $display("FAIL async_reset got res=%b vld=%b busy=%b time=%0d required 0/0/0/0",
                     res, vld, busy, atime);
        end
        tick();
        rst = 1'b0;
        repeat (8) tick();
        checks++;
        if (pulse_cnt != base || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_pulse got pulses=%0d busy=%b required 0 pulses busy=0",
                     pulse_cnt - base, busy);
        end
    endtask

    // Held DEC gives one judgement; DEC already high on entering INPUT gives none
    task automatic test_dec_hold();
        exp_t e;
        int   base;
        go_ready();
        base = pulse_cnt;
        e = '{res: 2'b01, res_np: 2'b01, t: 16'd6, t4: 4'd6};
        sb_q.push_back(e);
        state = INPUT; question = {12'h105, 12'h000};
        c1 = 4'd7; c2 = 4'd5; c3 = 4'd3;
        repeat (5) tick();
        dec = 1'b1;
        repeat (10) tick();
        dec = 1'b0;
        repeat (6) tick();
        checks++;
        if (pulse_cnt - base != 1) begin
            failures++;
            $display("FAIL dec_hold_one_pulse got=%0d required=1", pulse_cnt - base);
        end

        state = READY;
        dec = 1'b1;
        tick();
        tick();
        base = pulse_cnt;
        state = INPUT;
        repeat (8) tick();
        checks++;
        if (pulse_cnt != base || busy !== 1'b0) begin
            failures++;
            $display("FAIL dec_high_on_entry got pulses=%0d busy=%b required 0 pulses busy=0",
                     pulse_cnt - base, busy);
        end
        dec = 1'b0;
        tick();
    endtask

    task automatic test_time();
        do_judge(12'h105, 4'd3, 4'd5, 4'd7, 49, 2'b01, 2'b01);
        do_judge(12'h105, 4'd5, 4'd7, 4'd3, 19, 2'b01, 2'b01);
        do_judge(12'h105, 4'd3, 4'd7, 4'd5, 10, 2'b01, 2'b01);
    endtask

    task automatic test_ready_clear();
        checks++;
        if (res !== 2'b01) begin
            failures++;
            $display("FAIL result_hold got=%b required=01", res);
        end
        state = READY;
        tick();
        checks++;
        if (res !== 2'b00 || res_np !== 2'b00) begin
            failures++;
            $display("FAIL ready_clear got=%b/%b required=00/00", res, res_np);
        end
        do_judge(12'h008, 4'd2, 4'd2, 4'd2, 0, 2'b01, 2'b01);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrong();
        test_prime();
        test_invalid();
        test_abort();
        test_dec_hold();
        test_time();
        test_ready_clear();
        repeat (4) tick();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d pending verdicts required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
